arith_result_stage: RTL

Registered output stage directly downstream of the arithmetic adder/subtractor. It captures the adder's `result`/`carry_out` pair together with the operation selector and operand sign bits, derives the N/Z/C/V status flags, and hands result plus flags to the next pipeline stage over a valid/ready handshake. A two-entry skid buffer lets the upstream adder keep issuing while the consumer stalls, with no data loss and in-order delivery.

---
 rtl/arith_result_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/arith_result_stage.sv
// Registered result/flag stage behind the adder: captures result, carry and operand signs,
// derives {N,Z,C,V}, and buffers two words with a skid register. Optional macro: ARITH_STICKY_FLAGS_EN.
module arith_result_stage #(
    parameter int bus = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [bus-1:0] result,
    input  logic           carry_out,
    input  logic [1:0]     selector,
    input  logic           a_msb,
    input  logic           b_msb,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [bus-1:0] out_result,
    output logic [3:0]     out_flags,
    input  logic           clear_sticky,
    output logic           sticky_v
);

    // Handshake: a word moves on a rising edge only when valid && ready are both high;
    // ready never depends on valid, and the upstream holds its word while it is stalled.

    logic           main_valid_q, main_valid_d;
    logic [bus-1:0] main_result_q, main_result_d;
    logic [3:0]     main_flags_q, main_flags_d;
    logic           skid_valid_q, skid_valid_d;
    logic [bus-1:0] skid_result_q, skid_result_d;
    logic [3:0]     skid_flags_q, skid_flags_d;

    logic           in_xfer;
    logic           out_xfer;
    logic           is_add;
    logic           v_bit;
    logic [3:0]     in_flags;

    assign in_ready = !skid_valid_q && !rst;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid_q && out_ready;

    // Subtraction overflows when the operand signs differ; addition when they match.
    assign is_add   = (selector == 2'b00);
    assign v_bit    = (result[bus-1] != a_msb) && (is_add ? (a_msb == b_msb) : (a_msb != b_msb));
    assign in_flags = {result[bus-1], (result == '0), carry_out, v_bit};

    always_comb begin
        main_valid_d  = main_valid_q;
        main_result_d = main_result_q;
        main_flags_d  = main_flags_q;
        skid_valid_d  = skid_valid_q;
        skid_result_d = skid_result_q;
        skid_flags_d  = skid_flags_q;
        if (!main_valid_q) begin
            if (in_xfer) begin
                main_valid_d  = 1'b1;
                main_result_d = result;
                main_flags_d  = in_flags;
            end
        end else if (out_xfer) begin
            if (skid_valid_q) begin
                main_result_d = skid_result_q;
                main_flags_d  = skid_flags_q;
                skid_valid_d  = 1'b0;
            end else if (in_xfer) begin
                main_result_d = result;
                main_flags_d  = in_flags;
            end else begin
                main_valid_d  = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d  = 1'b1;
            skid_result_d = result;
            skid_flags_d  = in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q  <= 1'b0;
            main_result_q <= '0;
            main_flags_q  <= 4'b0000;
            skid_valid_q  <= 1'b0;
            skid_result_q <= '0;
            skid_flags_q  <= 4'b0000;
        end else begin
            main_valid_q  <= main_valid_d;
            main_result_q <= main_result_d;
            main_flags_q  <= main_flags_d;
            skid_valid_q  <= skid_valid_d;
            skid_result_q <= skid_result_d;
            skid_flags_q  <= skid_flags_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_result = main_result_q;
    assign out_flags  = main_flags_q;

`ifdef ARITH_STICKY_FLAGS_EN
    logic sticky_q, sticky_d;

    // A delivered overflow beats a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_xfer && main_flags_q[0]) begin
            sticky_d = 1'b1;
        end else if (clear_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_v = sticky_q;
`else
    logic unused_clear_sticky;
    assign unused_clear_sticky = clear_sticky;
    assign sticky_v            = 1'b0;
`endif

endmodule
